// File: rtl/csr_pkg.sv
// CSR operation codes and trap cause encodings used by the commit stage.
package csr_pkg;

   typedef enum logic [2:0] {
      CsrOpNone,
      CsrOpCsrrw,
      CsrOpCsrrs,
      CsrOpCsrrc,
      CsrOpFflags
   } csr_op_t;

   // Bit 5 flags an interrupt; bits 4:0 carry the mcause code.
   typedef logic [5:0] except_code_t;

   localparam except_code_t ExcIllegalInstr = 6'd2;
   localparam except_code_t ExcBreakpoint   = 6'd3;
   localparam except_code_t ExcEcallM       = 6'd11;
   localparam except_code_t IrqCauseMExt    = {1'b1, 5'd11};

endpackage

// File: rtl/expipe_pkg.sv
// Execution-pipeline types: commit classification and commit FSM states.
package expipe_pkg;

   typedef enum logic [3:0] {
      CommNone,
      CommIntRf,
      CommLoad,
      CommFpRf,
      CommLoadFp,
      CommIntRfFp,
      CommStore,
      CommBranch,
      CommJump,
      CommCsr,
      CommEcall,
      CommEbreak,
      CommExcept,
      CommMret,
      CommFence,
      CommWfi
   } comm_type_t;

   typedef enum logic [2:0] {
      StReset,
      StIdle,
      StMisFlush,
      StExcept,
      StMret,
      StFenceWait,
      StWfi
   } commit_state_t;

endpackage

// File: rtl/len5_pkg.sv
// Global LEN5 core parameters shared across pipeline stages.
package len5_pkg;

   localparam int unsigned XLEN = 32;

endpackage

// File: rtl/commit_cu.sv
// Commit control unit: retires the ROB head and serialises flushes, traps, MRET, FENCE and WFI.
// Define LEN5_FP_EN to enable FP_RF, LOAD_FP and INT_RF_FP commits (otherwise they trap).
module commit_cu
   import csr_pkg::*;
   import expipe_pkg::*;
#(
   parameter int unsigned XLEN = len5_pkg::XLEN
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            valid_i,
   output logic            ready_o,
   input  comm_type_t      comm_type_i,
   input  csr_op_t         csr_op_i,
   input  logic [XLEN-1:0] instr_pc_i,
   input  logic [XLEN-1:0] res_pc_i,
   input  logic            mispredict_i,
   input  except_code_t    except_code_i,
   output logic            int_rf_valid_o,
   output logic            fp_rf_valid_o,
   output logic            sb_valid_o,
   input  logic            sb_ready_i,
   input  logic            sb_empty_i,
   output logic            csr_valid_o,
   output csr_op_t         csr_op_o,
   output logic            csr_except_o,
   output except_code_t    csr_except_code_o,
   output logic [XLEN-1:0] csr_except_pc_o,
   output logic            csr_mret_o,
   input  logic [XLEN-1:0] mtvec_i,
   input  logic [XLEN-1:0] mepc_i,
   input  logic            irq_i,
   output logic            flush_o,
   output logic            fe_redirect_o,
   output logic [XLEN-1:0] fe_pc_o,
   output logic            instret_o
);

   commit_state_t   state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d, pc_plus4;
   except_code_t    cause_q, cause_d;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= StReset;
         pc_q    <= '0;
         cause_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cause_q <= cause_d;
      end
   end

   always_comb begin
      state_d           = state_q;
      pc_d              = pc_q;
      cause_d           = cause_q;
      ready_o           = 1'b0;
      int_rf_valid_o    = 1'b0;
      fp_rf_valid_o     = 1'b0;
      sb_valid_o        = 1'b0;
      csr_valid_o       = 1'b0;
      csr_op_o          = CsrOpNone;
      csr_except_o      = 1'b0;
      csr_except_code_o = '0;
      csr_except_pc_o   = '0;
      csr_mret_o        = 1'b0;
      flush_o           = 1'b0;
      fe_redirect_o     = 1'b0;
      fe_pc_o           = '0;
      pc_plus4          = instr_pc_i + XLEN'(4);

      unique case (state_q)
         StReset: state_d = StIdle;
         StIdle: begin
            // A pending interrupt wins over the head, even a store mid-handshake.
            if (irq_i) begin
               state_d = StExcept;
               cause_d = IrqCauseMExt;
               pc_d    = instr_pc_i;
            end else if (valid_i) begin
               unique case (comm_type_i)
                  CommIntRf, CommLoad: begin
                     int_rf_valid_o = 1'b1;
                     ready_o        = 1'b1;
                  end
                  CommStore: begin
                     sb_valid_o = 1'b1;
                     ready_o    = sb_ready_i;
                  end
                  CommBranch, CommJump: begin
                     int_rf_valid_o = (comm_type_i == CommJump);
                     ready_o        = 1'b1;
                     if (mispredict_i) begin
                        pc_d    = res_pc_i;
                        state_d = StMisFlush;
                     end
                  end
                  CommCsr: begin
                     csr_valid_o    = 1'b1;
                     csr_op_o       = csr_op_i;
                     int_rf_valid_o = 1'b1;
                     ready_o        = 1'b1;
                     pc_d           = pc_plus4;
                     state_d        = StMisFlush;
                  end
                  CommEcall, CommEbreak, CommExcept: begin
                     state_d = StExcept;
                     pc_d    = instr_pc_i;
                     cause_d = (comm_type_i == CommEcall)  ? ExcEcallM :
                               (comm_type_i == CommEbreak) ? ExcBreakpoint : except_code_i;
                  end
                  CommMret: begin
                     ready_o = 1'b1;
                     state_d = StMret;
                  end
                  CommFence: state_d = StFenceWait;
                  CommWfi: begin
                     ready_o = 1'b1;
                     pc_d    = pc_plus4;
                     state_d = StWfi;
                  end
`ifdef LEN5_FP_EN
                  CommFpRf: begin
                     fp_rf_valid_o = 1'b1;
                     csr_valid_o   = 1'b1;
                     csr_op_o      = csr_op_i;
                     ready_o       = 1'b1;
                  end
                  CommLoadFp: begin
                     fp_rf_valid_o = 1'b1;
                     ready_o       = 1'b1;
                  end
                  CommIntRfFp: begin
                     int_rf_valid_o = 1'b1;
                     csr_valid_o    = 1'b1;
                     csr_op_o       = csr_op_i;
                     ready_o        = 1'b1;
                  end
`else
                  CommFpRf, CommLoadFp, CommIntRfFp: begin
                     state_d = StExcept;
                     pc_d    = instr_pc_i;
                     cause_d = ExcIllegalInstr;
                  end
`endif
                  default: ;
               endcase
            end
         end
         StMisFlush: begin
            flush_o       = 1'b1;
            fe_redirect_o = 1'b1;
            fe_pc_o       = pc_q;
            state_d       = StIdle;
         end
         StExcept: begin
            csr_except_o      = 1'b1;
            csr_except_code_o = cause_q;
            csr_except_pc_o   = pc_q;
            flush_o           = 1'b1;
            fe_redirect_o     = 1'b1;
            fe_pc_o           = mtvec_i;
            state_d           = StIdle;
         end
         StMret: begin
            csr_mret_o    = 1'b1;
            flush_o       = 1'b1;
            fe_redirect_o = 1'b1;
            fe_pc_o       = mepc_i;
            state_d       = StIdle;
         end
         StFenceWait: begin
            if (sb_empty_i) begin
               ready_o = 1'b1;
               pc_d    = pc_plus4;
               state_d = StMisFlush;
            end
         end
         StWfi: begin
            if (irq_i) begin
               state_d = StExcept;
               cause_d = IrqCauseMExt;
            end
         end
         default: state_d = StReset;
      endcase

      instret_o = valid_i & ready_o;
   end

endmodule

// File: tb/tb_commit_cu.sv
// Self-checking bench for commit_cu: vector table for single-cycle commits plus hand sequences.
module tb_commit_cu;
   import csr_pkg::*;
   import expipe_pkg::*;

   typedef struct packed {
      logic         ready;
      logic         int_rf;
      logic         fp_rf;
      logic         sb;
      logic         csr_v;
      csr_op_t      csr_op;
      logic         exc;
      except_code_t exc_code;
      logic [31:0]  exc_pc;
      logic         mret;
      logic         flush;
      logic         redir;
      logic [31:0]  fe_pc;
      logic         instret;
   } outs_t;

   typedef struct packed {
      logic       valid;
      comm_type_t ct;
      logic       sbr;
      outs_t      exp;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         valid, ready, mispredict, int_rf_valid, fp_rf_valid, sb_valid, sb_ready;
   logic         sb_empty, csr_valid, csr_except, csr_mret, irq, flush, fe_redirect, instret;
   comm_type_t   comm_type;
   csr_op_t      csr_op_in, csr_op_out;
   except_code_t except_code, csr_except_code;
   logic [31:0]  instr_pc, res_pc, mtvec, mepc, fe_pc, csr_except_pc;

   outs_t got;
   outs_t exp_q[$];
   string name_q[$];
   vec_t  tbl[$];
   int    n_tests = 0;
   int    n_fail  = 0;

   always #5 clk = ~clk;

   commit_cu dut (
      .clk_i             (clk),
      .rst_n_i           (rst_n),
      .valid_i           (valid),
      .ready_o           (ready),
      .comm_type_i       (comm_type),
      .csr_op_i          (csr_op_in),
      .instr_pc_i        (instr_pc),
      .res_pc_i          (res_pc),
      .mispredict_i      (mispredict),
      .except_code_i     (except_code),
      .int_rf_valid_o    (int_rf_valid),
      .fp_rf_valid_o     (fp_rf_valid),
      .sb_valid_o        (sb_valid),
      .sb_ready_i        (sb_ready),
      .sb_empty_i        (sb_empty),
      .csr_valid_o       (csr_valid),
      .csr_op_o          (csr_op_out),
      .csr_except_o      (csr_except),
      .csr_except_code_o (csr_except_code),
      .csr_except_pc_o   (csr_except_pc),
      .csr_mret_o        (csr_mret),
      .mtvec_i           (mtvec),
      .mepc_i            (mepc),
      .irq_i             (irq),
      .flush_o           (flush),
      .fe_redirect_o     (fe_redirect),
      .fe_pc_o           (fe_pc),
      .instret_o         (instret)
   );

   always_comb begin
      got          = '0;
      got.ready    = ready;
      got.int_rf   = int_rf_valid;
      got.fp_rf    = fp_rf_valid;
      got.sb       = sb_valid;
      got.csr_v    = csr_valid;
      got.csr_op   = csr_op_out;
      got.exc      = csr_except;
      got.exc_code = csr_except_code;
      got.exc_pc   = csr_except_pc;
      got.mret     = csr_mret;
      got.flush    = flush;
      got.redir    = fe_redirect;
      got.fe_pc    = fe_pc;
      got.instret  = instret;
   end

   function automatic outs_t mk_o(input logic r, input logic ir, input logic fr, input logic sb,
                                  input logic cv, input csr_op_t op, input logic ins);
      outs_t o = '0;
      o.ready   = r;
      o.int_rf  = ir;
      o.fp_rf   = fr;
      o.sb      = sb;
      o.csr_v   = cv;
      o.csr_op  = op;
      o.instret = ins;
      return o;
   endfunction

   function automatic outs_t mk_f(input logic exc, input logic mret, input logic [31:0] pc,
                                  input except_code_t code, input logic [31:0] epc);
      outs_t o = '0;
      o.exc      = exc;
      o.mret     = mret;
      o.flush    = 1'b1;
      o.redir    = 1'b1;
      o.fe_pc    = pc;
      o.exc_code = code;
      o.exc_pc   = epc;
      return o;
   endfunction

   task automatic idle_in();
      valid       = 1'b0;
      comm_type   = CommIntRf;
      csr_op_in   = CsrOpNone;
      instr_pc    = 32'h0000_1000;
      res_pc      = '0;
      mispredict  = 1'b0;
      except_code = '0;
      sb_ready    = 1'b1;
      sb_empty    = 1'b1;
      irq         = 1'b0;
   endtask

   task automatic check_out();
      outs_t e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      n_tests++;
      if (got !== e) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", n, got, e);
      end
   endtask

   // Called at posedge+1 with inputs already applied; samples at negedge.
   task automatic cyc(input string name, input outs_t e);
      exp_q.push_back(e);
      name_q.push_back(name);
      @(negedge clk);
      check_out();
      @(posedge clk);
      #1;
   endtask

   initial begin
      mtvec = 32'h0000_0100;
      mepc  = 32'h0000_0200;
      idle_in();
      valid = 1'b1;
      rst_n = 1'b0;

      tbl.push_back('{1'b1, CommIntRf,  1'b1, mk_o(1, 1, 0, 0, 0, CsrOpNone, 1)});
      tbl.push_back('{1'b1, CommLoad,   1'b1, mk_o(1, 1, 0, 0, 0, CsrOpNone, 1)});
      tbl.push_back('{1'b1, CommStore,  1'b1, mk_o(1, 0, 0, 1, 0, CsrOpNone, 1)});
      tbl.push_back('{1'b1, CommStore,  1'b0, mk_o(0, 0, 0, 1, 0, CsrOpNone, 0)});
      tbl.push_back('{1'b1, CommBranch, 1'b1, mk_o(1, 0, 0, 0, 0, CsrOpNone, 1)});
      tbl.push_back('{1'b1, CommJump,   1'b1, mk_o(1, 1, 0, 0, 0, CsrOpNone, 1)});
      tbl.push_back('{1'b0, CommIntRf,  1'b1, mk_o(0, 0, 0, 0, 0, CsrOpNone, 0)});
      tbl.push_back('{1'b1, CommNone,   1'b1, mk_o(0, 0, 0, 0, 0, CsrOpNone, 0)});
`ifdef LEN5_FP_EN
      tbl.push_back('{1'b1, CommFpRf,    1'b1, mk_o(1, 0, 1, 0, 1, CsrOpCsrrs, 1)});
      tbl.push_back('{1'b1, CommLoadFp,  1'b1, mk_o(1, 0, 1, 0, 0, CsrOpNone, 1)});
      tbl.push_back('{1'b1, CommIntRfFp, 1'b1, mk_o(1, 1, 0, 0, 1, CsrOpCsrrs, 1)});
`endif

      @(posedge clk);
      #1;
      cyc("reset_hold", '0);
      rst_n = 1'b1;
      cyc("reset_release", '0);

      for (int i = 0; i < int'(tbl.size()); i++) begin
         idle_in();
         valid     = tbl[i].valid;
         comm_type = tbl[i].ct;
         sb_ready  = tbl[i].sbr;
         csr_op_in = CsrOpCsrrs;
         cyc($sformatf("tbl%0d", i), tbl[i].exp);
      end

      // Store back-pressure
      idle_in(); valid = 1'b1; comm_type = CommStore; sb_ready = 1'b0;
      for (int i = 0; i < 3; i++) cyc("store_wait", mk_o(0, 0, 0, 1, 0, CsrOpNone, 0));
      sb_ready = 1'b1;
      cyc("store_commit", mk_o(1, 0, 0, 1, 0, CsrOpNone, 1));

      // Branch mispredict, then an offered head is refused during the flush
      idle_in(); valid = 1'b1; comm_type = CommBranch; mispredict = 1'b1; res_pc = 32'h8000_0100;
      cyc("beq_commit", mk_o(1, 0, 0, 0, 0, CsrOpNone, 1));
      idle_in(); valid = 1'b1;
      cyc("beq_flush", mk_f(0, 0, 32'h8000_0100, '0, '0));
      cyc("beq_after", mk_o(1, 1, 0, 0, 0, CsrOpNone, 1));

      // Jump mispredict writes the int RF as well
      idle_in(); valid = 1'b1; comm_type = CommJump; mispredict = 1'b1; res_pc = 32'h0000_9000;
      cyc("jal_commit", mk_o(1, 1, 0, 0, 0, CsrOpNone, 1));
      idle_in();
      cyc("jal_flush", mk_f(0, 0, 32'h0000_9000, '0, '0));

      // Exception at head
      idle_in(); valid = 1'b1; comm_type = CommExcept; except_code = 6'd5; instr_pc = 32'h2000;
      cyc("exc_hold", '0);
      idle_in();
      cyc("exc_trap", mk_f(1, 0, 32'h100, 6'd5, 32'h2000));

      // ECALL / EBREAK causes
      idle_in(); valid = 1'b1; comm_type = CommEcall; instr_pc = 32'h6000;
      cyc("ecall_hold", '0);
      idle_in();
      cyc("ecall_trap", mk_f(1, 0, 32'h100, ExcEcallM, 32'h6000));
      idle_in(); valid = 1'b1; comm_type = CommEbreak; instr_pc = 32'h6004;
      cyc("ebreak_hold", '0);
      idle_in();
      cyc("ebreak_trap", mk_f(1, 0, 32'h100, ExcBreakpoint, 32'h6004));

      // FENCE waits for the store buffer to drain
      idle_in(); valid = 1'b1; comm_type = CommFence; instr_pc = 32'h3000; sb_empty = 1'b0;
      cyc("fence_idle", '0);
      for (int i = 0; i < 4; i++) cyc("fence_wait", '0);
      sb_empty = 1'b1;
      cyc("fence_commit", mk_o(1, 0, 0, 0, 0, CsrOpNone, 1));
      idle_in();
      cyc("fence_flush", mk_f(0, 0, 32'h3004, '0, '0));
      cyc("fence_done", '0);

      // WFI at the top of the address space: PC+4 wraps to 0
      idle_in(); valid = 1'b1; comm_type = CommWfi; instr_pc = 32'hFFFF_FFFC;
      cyc("wfi_commit", mk_o(1, 0, 0, 0, 0, CsrOpNone, 1));
      idle_in();
      for (int i = 0; i < 4; i++) cyc("wfi_sleep", '0);
      irq = 1'b1;
      cyc("wfi_wake", '0);
      irq = 1'b0;
      cyc("wfi_trap", mk_f(1, 0, 32'h100, IrqCauseMExt, 32'h0));

      // CSR access serialises with a flush to PC+4
      idle_in(); valid = 1'b1; comm_type = CommCsr; instr_pc = 32'h4000; csr_op_in = CsrOpCsrrw;
      cyc("csr_commit", mk_o(1, 1, 0, 0, 1, CsrOpCsrrw, 1));
      idle_in();
      cyc("csr_flush", mk_f(0, 0, 32'h4004, '0, '0));

      // MRET
      idle_in(); valid = 1'b1; comm_type = CommMret;
      cyc("mret_commit", mk_o(1, 0, 0, 0, 0, CsrOpNone, 1));
      idle_in();
      cyc("mret_flush", mk_f(0, 1, 32'h200, '0, '0));

      // Interrupt abandons a stalled store
      idle_in(); valid = 1'b1; comm_type = CommStore; sb_ready = 1'b0; irq = 1'b1;
      instr_pc = 32'h7000;
      cyc("irq_store", '0);
      idle_in();
      cyc("irq_trap", mk_f(1, 0, 32'h100, IrqCauseMExt, 32'h7000));

`ifndef LEN5_FP_EN
      begin
         comm_type_t fp_types[3];
         fp_types = '{CommFpRf, CommLoadFp, CommIntRfFp};
         for (int i = 0; i < 3; i++) begin
            idle_in(); valid = 1'b1; comm_type = fp_types[i]; instr_pc = 32'h5000;
            cyc("fp_illegal_hold", '0);
            idle_in();
            cyc("fp_illegal_trap", mk_f(1, 0, 32'h100, ExcIllegalInstr, 32'h5000));
         end
      end
`endif

      // Reset during a flush drops it
      idle_in(); valid = 1'b1; comm_type = CommBranch; mispredict = 1'b1; res_pc = 32'h0000_A000;
      cyc("rst_br_commit", mk_o(1, 0, 0, 0, 0, CsrOpNone, 1));
      idle_in(); valid = 1'b1; rst_n = 1'b0;
      cyc("rst_flush_cycle", mk_f(0, 0, 32'h0000_A000, '0, '0));
      cyc("rst_mid", '0);
      rst_n = 1'b1;
      cyc("rst_release2", '0);
      cyc("rst_idle", mk_o(1, 1, 0, 0, 0, CsrOpNone, 1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/commit_cu.md
# commit_cu

Commit control unit of the LEN5 commit stage. Consumes the commit type and CSR operation produced by the commit decoder for the ROB head entry, handshakes with the ROB, and drives register-file write enables, store-buffer commit, CSR updates, pipeline flush and front-end redirect. It is sequential: a state machine serialises long-latency commits, namely store back-pressure, misprediction, exceptions, MRET, WFI and FENCE.

## Interface
- `XLEN`: default `len5_pkg::XLEN`. PC and address width.
- `clk_i`  in  1  clock
- `rst_n_i`  in  1  reset. One clock; reset is synchronous and active-low.
- `valid_i`  in  1  ROB head valid
- `ready_o`  out  1  head committed this cycle (ROB pops on `valid_i & ready_o`)
- `comm_type_i`  in  `comm_type_t`  from commit decoder
- `csr_op_i`  in  `csr_op_t`  from commit decoder
- `instr_pc_i`  in  XLEN  head PC
- `res_pc_i`  in  XLEN  resolved branch/jump target
- `mispredict_i`  in  1  head branch/jump was mispredicted
- `except_code_i`  in  `except_code_t`  head exception cause
- `int_rf_valid_o`, `fp_rf_valid_o`  out  1  RF write enables
- `sb_valid_o`  out  1  commit oldest store
- `sb_ready_i`  in  1  store buffer accepts the commit
- `sb_empty_i`  in  1  store buffer drained
- `csr_valid_o`  out  1  CSR access / fflags update
- `csr_op_o`  out  `csr_op_t`
- `csr_except_o`  out  1  trap entry (writes mepc/mcause)
- `csr_mret_o`  out  1  MRET
- `mtvec_i`, `mepc_i`  in  XLEN  trap vector, return PC
- `irq_i`  in  1  pending enabled interrupt
- `flush_o`  out  1  flush all speculative state
- `fe_redirect_o`  out  1  front-end PC redirect
- `fe_pc_o`  out  XLEN  redirect target
- `instret_o`  out  1  one instruction retired

## Operation
- States: `RESET`, `IDLE`, `MIS_FLUSH`, `EXCEPT`, `MRET`, `FENCE_WAIT`, `WFI`.
- `RESET`: all outputs 0. Moves to `IDLE` on the first cycle with `rst_n_i`=1.
- `IDLE` with `valid_i`=1 commits according to `comm_type_i`:
  - INT_RF / LOAD: `int_rf_valid_o`=1, `ready_o`=1, `instret_o`=1.
  - FP_RF / LOAD_FP: `fp_rf_valid_o`=1. FP_RF also sets `csr_valid_o` with `csr_op_i` (fflags).
  - INT_RF_FP: `int_rf_valid_o`=1 and `csr_valid_o`=1.
  - STORE: `sb_valid_o`=1. `ready_o`=`sb_ready_i` (same-cycle). If `sb_ready_i`=0, stay in `IDLE` and hold.
  - BRANCH / JUMP: commit. JUMP also writes the int RF. If `mispredict_i`=1, latch `res_pc_i` and go to `MIS_FLUSH`.
  - CSR: `csr_valid_o`=1, `int_rf_valid_o`=1, commit. Latch `instr_pc_i+4` and go to `MIS_FLUSH`; CSRs are serialising.
  - ECALL / EBREAK / EXCEPT: no commit (`ready_o`=0). Latch cause and go to `EXCEPT`.
  - MRET: commit, go to `MRET`.
  - FENCE: go to `FENCE_WAIT`. No commit yet.
  - WFI: commit, latch `instr_pc_i+4`, go to `WFI`.
- `irq_i`=1 in `IDLE` has priority over any head commit: go to `EXCEPT` with an interrupt cause. A store handshake in flight with `sb_ready_i`=0 is abandoned.
- `MIS_FLUSH`: `flush_o`=1, `fe_redirect_o`=1, `fe_pc_o`=latched PC. Next state `IDLE`.
- `EXCEPT`: `csr_except_o`=1, `flush_o`=1, `fe_redirect_o`=1, `fe_pc_o`=`mtvec_i`. Next state `IDLE`.
- `MRET`: `csr_mret_o`=1, flush, redirect to `mepc_i`. Next state `IDLE`.
- `FENCE_WAIT`: hold until `sb_empty_i`=1. Then commit FENCE (`ready_o`=1) and go to `MIS_FLUSH` with `instr_pc_i+4`.
- `WFI`: hold until `irq_i`=1, then go to `EXCEPT`.
- `instret_o` = `valid_i & ready_o`.
- PC+4 is computed in XLEN and wraps modulo 2^XLEN.

## Timing
- Commit latency: 0 cycles. `ready_o` is combinational from state, `comm_type_i` and `sb_ready_i`.
- Flush/redirect is asserted for exactly 1 cycle, on the cycle after the triggering commit decision. While flushing, `ready_o`=0.
- All state and latched PC registers are reset synchronously. Reset mid-flush drops the flush and returns to `RESET`.
- Latched PC/cause registers reset to 0.

## Configuration
- `LEN5_FP_EN` defined: FP_RF, LOAD_FP and INT_RF_FP are handled as described in Operation.
- `LEN5_FP_EN` undefined: those three types go to `EXCEPT` with illegal-instruction cause, and `fp_rf_valid_o` is tied to 0.

## Structure
- `expipe_pkg` holds `comm_type_t` and the new `commit_state_t` enum.
- `csr_pkg` holds `csr_op_t`, `except_code_t` and the interrupt cause constant.
- Single module, no sub-modules. The FSM and latch registers live in one `always_ff`; outputs come from one `always_comb`.

## Test plan
- ADDI at head, `valid_i`=1 → same cycle: `ready_o`=1, `int_rf_valid_o`=1, `instret_o`=1.
- STORE with `sb_ready_i`=0 for 3 cycles, then 1 → `sb_valid_o`=1 for 4 cycles, `ready_o`=1 only in the 4th.
- BEQ with `mispredict_i`=1, `res_pc_i`=0x8000_0100 → next cycle `flush_o`=1, `fe_pc_o`=0x8000_0100 for 1 cycle.
- EXCEPT type, `mtvec_i`=0x100 → `ready_o` stays 0; next cycle `csr_except_o`=1, `fe_pc_o`=0x100.
- FENCE with `sb_empty_i`=0 for 5 cycles → commit on the first `sb_empty_i`=1 cycle, then flush to PC+4.
- WFI at PC 0xFFFF_FFFC, then `irq_i` after 4 cycles → trap to `mtvec_i`; wrapped PC latched as 0.
